uart_tx_reg_module: RTL

UART_TX_REG_MODULE -- requirements
Module: uart_tx_reg_module

---
 rtl/uart_tx_reg_module_if.sv | 39 +++
 rtl/uart_tx_reg_module.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_tx_reg_module_if.sv
// Word-in / byte-out handshake bundle for the register serializer.
// The slave side is the serializer; the master side is its environment.
interface uart_tx_reg_module_if #(
    parameter int REG_WIDTH = 32
);
    logic [REG_WIDTH-1:0] reg_data;
    logic                 reg_valid;
    logic                 reg_ready;
    logic                 tx_abort;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_ack;
    logic                 tx_frame_done;
    logic                 busy;

    modport master (
        output reg_data,
        output reg_valid,
        output tx_abort,
        output tx_ack,
        input  reg_ready,
        input  tx_data,
        input  tx_data_valid,
        input  tx_frame_done,
        input  busy
    );

    modport slave (
        input  reg_data,
        input  reg_valid,
        input  tx_abort,
        input  tx_ack,
        output reg_ready,
        output tx_data,
        output tx_data_valid,
        output tx_frame_done,
        output busy
    );
endinterface

// File: rtl/uart_tx_reg_module.sv
// Serializes a REG_WIDTH-bit word into bytes, MSB first, for a UART byte
// transmitter, with an optional idle gap between bytes and a frame-done pulse.
module uart_tx_reg_module #(
    parameter int REG_WIDTH  = 32,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_reg_module_if.slave   bus
);
    localparam int N     = REG_WIDTH / 8;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [REG_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]          gap_cnt_q, gap_cnt_d;
    logic                 reg_ready_q, reg_ready_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;

    // Abort drops the rest of the frame, so all datapath state is cleared with it.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.reg_valid && !bus.tx_abort) begin
                    shift_d    = bus.reg_data;
                    byte_cnt_d = CNT_W'(N);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.tx_abort) begin
                    shift_d    = '0;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = IDLE;
                end else if (bus.tx_ack) begin
                    shift_d    = shift_q << 8;
                    byte_cnt_d = byte_cnt_q - CNT_W'(1);
                    gap_cnt_d  = '0;
                    state_d    = (byte_cnt_q == CNT_W'(1)) ? DONE : GAP;
                end
            end
            GAP: begin
                if (bus.tx_abort) begin
                    shift_d    = '0;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = IDLE;
                end else if (gap_cnt_q == 16'(GAP_CYCLES)) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            DONE: begin
                shift_d    = '0;
                byte_cnt_d = '0;
                gap_cnt_d  = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        reg_ready_d  = (state_d == IDLE);
        tx_valid_d   = (state_d == SEND);
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            reg_ready_q  <= 1'b1;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            reg_ready_q  <= reg_ready_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.reg_ready     = reg_ready_q;
    assign bus.tx_data       = shift_q[REG_WIDTH-1 -: 8];
    assign bus.tx_data_valid = tx_valid_q;
    assign bus.tx_frame_done = frame_done_q;
    assign bus.busy          = busy_q;
endmodule
